vga_timing_gen: RTL



---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_delay_line.sv | 33 +++
 rtl/vga_timing_gen.sv | 92 +++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60) and the sync/blank bundle type,
// used by the timing generator and the pixel generator.
package vga_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FP     = 16;
   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_BP     = 48;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BP     = 33;

   function automatic int unsigned span_total(input int unsigned act, input int unsigned fp,
                                              input int unsigned syn, input int unsigned bp);
      return act + fp + syn + bp;
   endfunction

   localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic blank_b;
   } vga_sync_t;

   localparam vga_sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank_b: 1'b0};

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
   parameter int unsigned      WIDTH   = 1,
   parameter int unsigned      DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign dout = din;
      end else begin : g_shift
         logic [WIDTH-1:0] stg [DEPTH];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int unsigned i = 0; i < DEPTH; i++) stg[i] <= RST_VAL;
            end else if (en) begin
               stg[0] <= din;
               for (int unsigned i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
            end
         end

         assign dout = stg[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-tick divider, x/y raster counters, and sync/blank
// decode delayed to line up with the downstream pixel stage.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned HACTIVE  = H_ACTIVE,
   parameter int unsigned HFP      = H_FP,
   parameter int unsigned HSYN     = H_SYNC,
   parameter int unsigned HBP      = H_BP,
   parameter int unsigned VACTIVE  = V_ACTIVE,
   parameter int unsigned VFP      = V_FP,
   parameter int unsigned VSYN     = V_SYNC,
   parameter int unsigned VBP      = V_BP,
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned PIPE_DLY = 1
) (
   input  logic       clk,
   input  logic       reset,
   output logic       pix_en,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hsync,
   output logic       vsync,
   output logic       sync_b,
   output logic       blank_b,
   output logic       frame_start
);

   localparam int unsigned HTOTAL = span_total(HACTIVE, HFP, HSYN, HBP);
   localparam int unsigned VTOTAL = span_total(VACTIVE, VFP, VSYN, VBP);

   logic [2:0] div;
   logic       div_last;
   logic [9:0] x_nxt, y_nxt;
   vga_sync_t  sync_raw, sync_dly;

   always_comb begin
      div_last = (div == 3'(CLK_DIV - 1));
      x_nxt    = x;
      y_nxt    = y;
      if (pix_en) begin
         if (x == 10'(HTOTAL - 1)) begin
            x_nxt = '0;
            y_nxt = (y == 10'(VTOTAL - 1)) ? '0 : y + 10'd1;
         end else begin
            x_nxt = x + 10'd1;
         end
      end
   end

   // pix_en lags the divider by one clk so the first tick after reset lands
   // CLK_DIV edges later; frame_start looks at the post-edge raster position.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div         <= '0;
         pix_en      <= 1'b0;
         x           <= '0;
         y           <= '0;
         frame_start <= 1'b0;
      end else begin
         div         <= div_last ? '0 : div + 3'd1;
         pix_en      <= div_last;
         x           <= x_nxt;
         y           <= y_nxt;
         frame_start <= div_last && (x_nxt == '0) && (y_nxt == '0);
      end
   end

   always_comb begin
      sync_raw.hsync   = !((x >= 10'(HACTIVE + HFP)) && (x < 10'(HACTIVE + HFP + HSYN)));
      sync_raw.vsync   = !((y >= 10'(VACTIVE + VFP)) && (y < 10'(VACTIVE + VFP + VSYN)));
      sync_raw.blank_b = (x < 10'(HACTIVE)) && (y < 10'(VACTIVE));
   end

   vga_delay_line #(
      .WIDTH   ($bits(vga_sync_t)),
      .DEPTH   (PIPE_DLY),
      .RST_VAL (SYNC_IDLE)
   ) u_dly (
      .clk   (clk),
      .reset (reset),
      .en    (pix_en),
      .din   (sync_raw),
      .dout  (sync_dly)
   );

   assign hsync   = sync_dly.hsync;
   assign vsync   = sync_dly.vsync;
   assign blank_b = sync_dly.blank_b;
   assign sync_b  = 1'b0;

endmodule
